// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: shared constants for the cpu_param slice.
//   state_t  : FSM state encoding
//   OPC_* / OP_* : opcode (IR[15:13]) and sub-op (IR[12:11]) codes
//   SH_*     : B-operand shift codes (IR[4:3])
package cpu_param_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_IMM,
    S_WRITE
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // sub-ops under OPC_MOV
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  // sub-ops under OPC_ALU
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/cpu_param_if.sv
// cpu_param_if: control/data bundle between the CPU and its driver.
//   s, load, in       : start, IR-load strobe, 16-bit instruction word
//   out, N, V, Z, w   : result register C, status flags, idle/ready
// master = driver side, slave = cpu_param side.
interface cpu_param_if #(parameter int unsigned DATA_W = 16);
  logic              s;
  logic              load;
  logic [15:0]       in;
  logic [DATA_W-1:0] out;
  logic              N;
  logic              V;
  logic              Z;
  logic              w;

  modport master (output s, load, in, input out, N, V, Z, w);
  modport slave  (input s, load, in, output out, N, V, Z, w);
endinterface

// File: rtl/cpu_param_regfile.sv
// cpu_param_regfile: NREG x DATA_W register storage.
//   clk, reset          : clock, synchronous active-high clear of all registers
//   we, waddr, wdata    : single write port
//   raddr_a/rdata_a,
//   raddr_b/rdata_b     : two combinational read ports
// Addresses >= NREG read as zero and ignore writes.
module cpu_param_regfile
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam logic [3:0] NREG_L = 4'(NREG);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && ({1'b0, waddr} < NREG_L)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = ({1'b0, raddr_a} < NREG_L) ? regs[raddr_a] : '0;
  assign rdata_b = ({1'b0, raddr_b} < NREG_L) ? regs[raddr_b] : '0;

endmodule

// File: rtl/cpu_param.sv
// cpu_param: multi-cycle 16-bit-instruction CPU with parameterised datapath.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : cpu_param_if.slave (s, load, in -> out, N, V, Z, w)
// Optional build macro CPU_SAT_ADD_EN: ADD saturates on signed overflow
// instead of wrapping (CMP always wraps).
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic         clk,
  input  logic         reset,
  cpu_param_if.slave   bus
);

  state_t state, next_state;

  logic [15:0]       ir;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic              n_flag, v_flag, z_flag;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_mvn     = is_alu && (op == OP_MVN);

  logic [DATA_W-1:0] rd_a, rd_b, imm_sext;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign imm_sext = {{(DATA_W-8){ir[7]}}, ir[7:0]};
  assign rf_we    = (state == S_WRITE_IMM) || (state == S_WRITE);
  assign rf_waddr = (state == S_WRITE_IMM) ? rn : rd;
  assign rf_wdata = (state == S_WRITE_IMM) ? imm_sext : c_reg;

  cpu_param_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rn),
    .raddr_b (rm),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // shifter and ALU
  logic [DATA_W-1:0] b_sh, sum, diff, add_res, alu_res;
  logic              sub_ovf;

  always_comb begin
    b_sh = b_reg;
    unique case (sh)
      SH_NONE: b_sh = b_reg;
      SH_LSL:  b_sh = {b_reg[DATA_W-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b_reg[DATA_W-1:1]};
      SH_ASR:  b_sh = {b_reg[DATA_W-1], b_reg[DATA_W-1:1]};
    endcase
  end

  assign sum     = a_reg + b_sh;
  assign diff    = a_reg - b_sh;
  assign sub_ovf = (a_reg[DATA_W-1] != b_sh[DATA_W-1]) && (diff[DATA_W-1] != a_reg[DATA_W-1]);

`ifdef CPU_SAT_ADD_EN
  logic add_ovf;
  assign add_ovf = (a_reg[DATA_W-1] == b_sh[DATA_W-1]) && (sum[DATA_W-1] != a_reg[DATA_W-1]);
  // both operands share a sign on overflow, so a's MSB picks the rail
  assign add_res = !add_ovf       ? sum :
                   a_reg[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                     {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign add_res = sum;
`endif

  always_comb begin
    alu_res = b_sh;
    if (is_alu) begin
      unique case (op)
        OP_ADD:  alu_res = add_res;
        OP_AND:  alu_res = a_reg & b_sh;
        OP_MVN:  alu_res = ~b_sh;
        default: alu_res = diff;
      endcase
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.w      = 1'b0;
    unique case (state)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                next_state = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn) next_state = S_GET_B;
        else if (is_alu)               next_state = S_GET_A;
        else                           next_state = S_WAIT;
      end
      S_GET_A:     next_state = S_GET_B;
      S_GET_B:     next_state = S_EXEC;
      S_EXEC:      next_state = is_cmp ? S_WAIT : S_WRITE;
      S_WRITE_IMM: next_state = S_WAIT;
      S_WRITE:     next_state = S_WAIT;
      default:     next_state = S_WAIT;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ir     <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      c_reg  <= '0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (state == S_WAIT && bus.load) ir <= bus.in;
      if (state == S_GET_A) a_reg <= rd_a;
      if (state == S_GET_B) b_reg <= rd_b;
      if (state == S_EXEC) begin
        if (is_cmp) begin
          n_flag <= diff[DATA_W-1];
          z_flag <= (diff == '0);
          v_flag <= sub_ovf;
        end else begin
          c_reg <= alu_res;
        end
      end
    end
  end

  assign bus.out = c_reg;
  assign bus.N   = n_flag;
  assign bus.V   = v_flag;
  assign bus.Z   = z_flag;

endmodule

// File: tb/tb_cpu_param.sv
module tb_cpu_param;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cpu_param_if #(.DATA_W(16)) bus ();

  cpu_param #(
    .DATA_W (16),
    .NREG   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Optionally load word, pulse s, count edges until w returns high.
  // With disturb set, load/s are driven with a different word while busy.
  task automatic run(input logic [15:0] word, input bit do_load, input bit disturb,
                     input int exp_edges, input string tag);
    int n;
    if (do_load) begin
      @(negedge clk);
      bus.load = 1'b1;
      bus.in   = word;
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.s    = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.s = 1'b0;
    while (!bus.w && n < 40) begin
      if (disturb) begin
        bus.load = 1'b1;
        bus.in   = 16'hD2FF;
        bus.s    = 1'b1;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.load = 1'b0;
      bus.s    = 1'b0;
    end
    chk({tag, " edges"}, n, exp_edges);
  endtask

  task automatic exec_out(input logic [15:0] word, input int exp_edges,
                          input logic [15:0] exp_out, input string tag);
    run(word, 1'b1, 1'b0, exp_edges, tag);
    chk({tag, " out"}, bus.out, exp_out);
  endtask

  initial begin
    bus.s    = 1'b0;
    bus.load = 1'b0;
    bus.in   = '0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset out", bus.out, 16'h0000);
    chk("reset flags", {bus.N, bus.V, bus.Z}, 3'b000);
    chk("reset w", bus.w, 1'b1);

    exec_out(16'hD007, 3, 16'h0000, "mov r0,#7");
    exec_out(16'hC068, 5, 16'h000E, "mov r3,r0 lsl");
    exec_out(16'hD102, 3, 16'h000E, "mov r1,#2");
    exec_out(16'hA148, 6, 16'h0010, "add r2");
    exec_out(16'hC0E2, 5, 16'h0010, "read r2");

    exec_out(16'hD6FF, 3, 16'h0010, "mov r6,#-1");
    exec_out(16'hD5FF, 3, 16'h0010, "mov r5,#-1");
    exec_out(16'hC0B5, 5, 16'h7FFF, "mov r5 lsr");
    exec_out(16'hAD06, 5, 16'h7FFF, "cmp r5,r6");
    chk("cmp flags nvz", {bus.N, bus.V, bus.Z}, 3'b110);
    exec_out(16'hC0E5, 5, 16'h7FFF, "read r5");
    exec_out(16'hC09E, 5, 16'hFFFF, "mov r4,r6 asr");
    chk("flags hold", {bus.N, bus.V, bus.Z}, 3'b110);
    exec_out(16'hB583, 6, 16'h000E, "and r4");
    exec_out(16'hB883, 5, 16'hFFF1, "mvn r4");
    exec_out(16'hAB03, 5, 16'hFFF1, "cmp r3,r3");
    chk("cmp eq flags", {bus.N, bus.V, bus.Z}, 3'b001);
    exec_out(16'hE000, 2, 16'hFFF1, "noop");
    chk("noop flags", {bus.N, bus.V, bus.Z}, 3'b001);

    // load and s wiggled during execution must not disturb ADD
    run(16'hA148, 1'b1, 1'b1, 6, "add busy");
    chk("add busy out", bus.out, 16'h0010);
    run(16'h0000, 1'b0, 1'b0, 6, "rerun ir");
    chk("rerun ir out", bus.out, 16'h0010);

    // reset in EXEC of ADD R2
    exec_out(16'hD205, 3, 16'h0010, "mov r2,#5");
    @(negedge clk);
    bus.load = 1'b1;
    bus.in   = 16'hA148;
    @(negedge clk);
    bus.load = 1'b0;
    bus.s    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort out", bus.out, 16'h0000);
    chk("abort flags", {bus.N, bus.V, bus.Z}, 3'b000);
    chk("abort w", bus.w, 1'b1);
    run(16'h0000, 1'b0, 1'b0, 2, "ir cleared");
    exec_out(16'hC0E2, 5, 16'h0000, "read r2 cleared");

    // signed overflow on ADD
    exec_out(16'hD1FF, 3, 16'h0000, "mov r1,#-1");
    exec_out(16'hC031, 5, 16'h7FFF, "mov r1 lsr");
    exec_out(16'hD001, 3, 16'h7FFF, "mov r0,#1");
    exec_out(16'hC0E0, 5, 16'h0001, "read r0");
`ifdef CPU_SAT_ADD_EN
    exec_out(16'hA140, 6, 16'h7FFF, "add ovf");
`else
    exec_out(16'hA140, 6, 16'h8000, "add ovf");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 Parameter DATA_W, default 16, datapath/register width; legal range 16..32.
REQ-002 Parameter NREG, default 8, number of implemented registers; legal range 2..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s  input  1  start: begin executing the held instruction.
REQ-006 load  input  1  capture in into instruction register (IR).
REQ-007 in  input  16  instruction word.
REQ-008 out  output  DATA_W  result register C.
REQ-009 N, V, Z  output  1 each  status flags: negative, signed overflow, zero.
REQ-010 w  output  1  high when idle and ready for load/s.

Function
REQ-011 The IR SHALL load in on a clock edge with load=1 only while in state WAIT; load is ignored in every other state.
REQ-012 Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0], imm8=IR[7:0].
REQ-013 Decoding: 110/10 MOV Rn,#imm8 (sign-extended to DATA_W); 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}.
REQ-014 Undefined opcode/op SHALL act as a no-op: DECODE returns to WAIT with no register, out or flag change.
REQ-015 Shifter on the B operand: sh=00 pass, 01 LSL by 1, 10 LSR by 1 (MSB filled with 0), 11 ASR by 1 (MSB replicated).
REQ-016 States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_IMM, WRITE.
REQ-017 WAIT→DECODE on s=1; s is ignored outside WAIT.
REQ-018 MOV imm: DECODE→WRITE_IMM→WAIT; w returns high 3 edges after s is sampled.
REQ-019 MOV reg and MVN: DECODE→GET_B→EXEC→WRITE→WAIT (5 edges).
REQ-020 ADD and AND: DECODE→GET_A→GET_B→EXEC→WRITE→WAIT (6 edges).
REQ-021 CMP: DECODE→GET_A→GET_B→EXEC→WAIT (5 edges); no register write.
REQ-022 w SHALL be 1 exactly when state is WAIT.
REQ-023 out SHALL update in EXEC for MOV reg, ADD, AND and MVN; it SHALL hold for CMP, MOV imm and no-op.
REQ-024 N, V and Z SHALL update in EXEC for CMP only; they reflect the result of A−B: N=MSB, Z=(result==0), V=signed overflow of the subtraction.
REQ-025 Arithmetic is modulo 2^DATA_W unless REQ-030 applies.
REQ-026 Register index ≥ NREG: a read returns 0 and a write is discarded.
REQ-027 Register writes happen only in WRITE (Rd←C) and WRITE_IMM (Rn←sext(imm8)).

Reset
REQ-028 With reset=1 at an edge: state←WAIT, IR←0, all registers←0, out←0, N=V=Z←0, w=1 from the following cycle; reset overrides load and s.
REQ-029 Reset asserted mid-instruction SHALL abort it with no register write, and the next state is WAIT.

Configuration
REQ-030 With macro CPU_SAT_ADD_EN defined, ADD SHALL saturate on signed overflow: positive overflow gives 0 followed by all 1s (max positive), negative overflow gives 1 followed by all 0s (min negative). Without the macro, ADD wraps. CMP is unaffected in both cases.

Structure
REQ-031 Package cpu_param_pkg SHALL hold the opcode/op constants, shift codes and state encoding.
REQ-032 Sub-module cpu_param_regfile (NREG x DATA_W, 1 write port, 2 read ports) SHALL contain the register storage; the ALU and shifter are inline.

Verification (DATA_W=16, NREG=8)
REQ-033 Load 0xD007 (MOV R0,#7), pulse s → w low, then high 3 edges later; R0=7; out unchanged.
REQ-034 Then load 0xC068 (MOV R3,R0,LSL#1) and 0xD102 (MOV R1,#2), then 0xA148 (ADD R2,R1,R0,LSL#1) → out=16 after 6 edges; R2=16.
REQ-035 Load a CMP with R5=0x7FFF, R6=0xFFFF → N=1, V=1, Z=0; out unchanged; no register written.
REQ-036 Assert load with a new word while executing ADD → IR unchanged and the result is still correct; s pulses while w=0 are ignored.
REQ-037 Assert reset in EXEC of ADD R2 → R2 is not written, out=0, flags=0, w=1 on the next cycle.
REQ-038 ADD 0x7FFF+0x0001: with CPU_SAT_ADD_EN → out=0x7FFF; without the macro → out=0x8000.
